// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: start detect, oversample edge/bit counters, checker strobes.
// Build option UART_RX_GLITCH_FILTER_EN: a start needs RX_IN low on two consecutive cycles.
//
//   state    | meaning
//   S_IDLE   | line idle, waiting for a low sample
//   S_START  | inside start bit, start check at its last edge
//   S_DATA   | data bits 1..8, deserializer shift at each bit end
//   S_PARITY | parity bit, parity check at its last edge
//   S_STOP   | stop bit, stop check at its last edge
//   S_DONE   | one cycle, data_valid if the frame was clean
module uart_rx_ctrl (
  input  logic       clk,
  input  logic       rstn,
  input  logic       RX_IN,
  input  logic [5:0] prescale,
  input  logic       parity_enable,
  input  logic       start_glitch,
  input  logic       parity_error,
  input  logic       stop_error,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       samp_en,
  output logic       deser_en,
  output logic       start_chk_en,
  output logic       par_chk_en,
  output logic       stop_chk_en,
  output logic       data_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] edge_q, edge_d;
  logic [5:0] p_q, p_d, p_legal;
  logic [3:0] bit_q, bit_d;
  logic       par_en_q, par_en_d;
  logic       err_q, err_d;
  logic       eob, eob_d, start_det;
  logic       samp_en_q, deser_en_q, start_chk_q, par_chk_q, stop_chk_q;
  logic       data_valid_q, busy_q;

`ifdef UART_RX_GLITCH_FILTER_EN
  localparam logic [5:0] ENTRY_EDGE = 6'd2;
  logic rx_prev_q;
  assign start_det = ~RX_IN & ~rx_prev_q;

  always_ff @(posedge clk) begin
    if (!rstn) rx_prev_q <= 1'b1;
    else       rx_prev_q <= RX_IN;
  end
`else
  localparam logic [5:0] ENTRY_EDGE = 6'd1;
  assign start_det = ~RX_IN;
`endif

  always_comb begin
    p_legal  = (prescale == 6'd8 || prescale == 6'd16) ? prescale : 6'd32;
    eob      = (edge_q == p_q - 6'd1);
    state_d  = state_q;
    edge_d   = edge_q;
    bit_d    = bit_q;
    p_d      = p_q;
    par_en_d = par_en_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        edge_d  = '0;
        bit_d   = '0;
        err_d   = 1'b0;
        // the detecting cycle is edge 0, so the frame enters START already advanced
        if (start_det) begin
          state_d  = S_START;
          edge_d   = ENTRY_EDGE;
          p_d      = p_legal;
          par_en_d = parity_enable;
        end
      end
      default: begin
        if (!eob) begin
          edge_d = edge_q + 6'd1;
        end else begin
          edge_d = '0;
          bit_d  = bit_q + 4'd1;
          case (state_q)
            S_START: begin
              if (start_glitch) begin
                state_d = S_IDLE;
                bit_d   = '0;
              end else begin
                state_d = S_DATA;
              end
            end
            S_DATA: begin
              if (bit_q == 4'd8) state_d = par_en_q ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
              err_d   = err_q | parity_error;
              state_d = S_STOP;
            end
            S_STOP: begin
              err_d   = err_q | stop_error;
              state_d = S_DONE;
              bit_d   = '0;
            end
            default: ;
          endcase
        end
      end
    endcase
    eob_d = (edge_d == p_d - 6'd1);
  end

  // outputs are registered from next-state values so they line up with the counters
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      edge_q       <= '0;
      bit_q        <= '0;
      p_q          <= 6'd32;
      par_en_q     <= 1'b0;
      err_q        <= 1'b0;
      samp_en_q    <= 1'b0;
      deser_en_q   <= 1'b0;
      start_chk_q  <= 1'b0;
      par_chk_q    <= 1'b0;
      stop_chk_q   <= 1'b0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      edge_q       <= edge_d;
      bit_q        <= bit_d;
      p_q          <= p_d;
      par_en_q     <= par_en_d;
      err_q        <= err_d;
      samp_en_q    <= (state_d == S_START) || (state_d == S_DATA) ||
                      (state_d == S_PARITY) || (state_d == S_STOP);
      deser_en_q   <= (state_d == S_DATA) && eob_d;
      start_chk_q  <= (state_d == S_START) && eob_d;
      par_chk_q    <= (state_d == S_PARITY) && eob_d;
      stop_chk_q   <= (state_d == S_STOP) && eob_d;
      data_valid_q <= (state_d == S_DONE) && !err_d;
      busy_q       <= (state_d != S_IDLE);
    end
  end

  assign edge_cnt     = edge_q;
  assign bit_cnt      = bit_q;
  assign samp_en      = samp_en_q;
  assign deser_en     = deser_en_q;
  assign start_chk_en = start_chk_q;
  assign par_chk_en   = par_chk_q;
  assign stop_chk_en  = stop_chk_q;
  assign data_valid   = data_valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: frames push expected strobe events, a monitor pops them.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] prescale = 6'd16;
  logic       parity_enable = 1'b0;
  logic       start_glitch = 1'b0;
  logic       parity_error = 1'b0;
  logic       stop_error = 1'b0;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       samp_en, deser_en, start_chk_en, par_chk_en, stop_chk_en, data_valid, busy;

  uart_rx_ctrl dut (
    .clk(clk), .rstn(rstn), .RX_IN(RX_IN), .prescale(prescale),
    .parity_enable(parity_enable), .start_glitch(start_glitch),
    .parity_error(parity_error), .stop_error(stop_error),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .samp_en(samp_en), .deser_en(deser_en),
    .start_chk_en(start_chk_en), .par_chk_en(par_chk_en), .stop_chk_en(stop_chk_en),
    .data_valid(data_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int kind; int at; } ev_t;
  ev_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  function automatic string kname(input int k);
    case (k)
      0: return "start_chk_en";
      1: return "deser_en";
      2: return "par_chk_en";
      3: return "stop_chk_en";
      default: return "data_valid";
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // monitor: every strobe the DUT raises must match the head of the expected queue
  always @(negedge clk) begin
    logic [4:0] s;
    ev_t e;
    s = {data_valid, stop_chk_en, par_chk_en, deser_en, start_chk_en};
    for (int k = 0; k < 5; k++) begin
      if (s[k] === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: got %s at cycle %0d, expected none", kname(k), cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.kind != k || e.at != cyc) begin
            n_fail++;
            $display("FAIL event_order: got %s at cycle %0d expected %s at cycle %0d",
                     kname(k), cyc, kname(e.kind), e.at);
          end
        end
      end
    end
  end

  function automatic void push(input int k, input int t, input int t0, input int abort_at);
    ev_t e;
    if (abort_at < 0 || t <= t0 + abort_at) begin
      e.kind = k;
      e.at   = t;
      exp_q.push_back(e);
    end
  endfunction

  // Drives one frame starting in the current cycle (t0); called at a negedge.
  task automatic send_frame(input logic [5:0] pcfg, input int p, input logic [7:0] data,
                            input bit par, input bit glitch, input bit perr, input bit serr,
                            input bit chg, input int abort_at);
    int t0, n;
    logic [10:0] line;
    t0 = cyc;
    prescale = pcfg;
    parity_enable = par;
    line[0] = 1'b0;
    for (int b = 1; b <= 8; b++) line[b] = data[b-1];
    line[9]  = par ? ^data : 1'b1;
    line[10] = 1'b1;
    push(0, t0 + p - 1, t0, abort_at);
    if (!glitch) begin
      for (int k = 1; k <= 8; k++) push(1, t0 + k*p + p - 1, t0, abort_at);
      if (par) begin
        push(2, t0 + 10*p - 1, t0, abort_at);
        push(3, t0 + 11*p - 1, t0, abort_at);
        if (!perr && !serr) push(4, t0 + 11*p, t0, abort_at);
      end else begin
        push(3, t0 + 10*p - 1, t0, abort_at);
        if (!serr) push(4, t0 + 10*p, t0, abort_at);
      end
    end
    n = glitch ? p : (par ? 11 : 10) * p;
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        rstn = 1'b0;
        start_glitch = 1'b0; parity_error = 1'b0; stop_error = 1'b0;
        @(negedge clk);
        check("midframe_reset_outputs",
              {edge_cnt, bit_cnt, samp_en, deser_en, start_chk_en, par_chk_en,
               stop_chk_en, data_valid, busy}, 32'd0);
        rstn = 1'b1;
        RX_IN = 1'b1;
        return;
      end
      if (i == 2) begin
        check("entry_edge_cnt", edge_cnt, 32'd2);
        check("entry_busy_samp", {busy, samp_en}, 32'd3);
      end
      if (i == p) check("first_data_counters", {bit_cnt, edge_cnt}, {26'd0, 4'd1, 6'd0} >> 0);
      if (chg && i == 5) begin
        prescale = 6'd8;
        parity_enable = ~par;
      end
      RX_IN        = line[i/p];
      start_glitch = glitch && (i == p - 1);
      parity_error = perr && (i == 10*p - 1);
      stop_error   = serr && (i == n - 1);
      @(negedge clk);
    end
    RX_IN = 1'b1;
    start_glitch = 1'b0; parity_error = 1'b0; stop_error = 1'b0;
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {edge_cnt, bit_cnt, samp_en, deser_en, start_chk_en, par_chk_en,
           stop_chk_en, data_valid, busy}, 32'd0);
    rstn = 1'b1;
    idle(4);
    check("idle_busy", {busy, samp_en, edge_cnt}, 32'd0);

    // clean frame, even parity, P=32
    send_frame(6'd32, 32, 8'b10110100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    check("clean_done_busy", busy, 32'd1);
    @(negedge clk);
    check("clean_back_idle", {busy, edge_cnt, bit_cnt}, 32'd0);
    idle(5);

    // no parity, P=16
    send_frame(6'd16, 16, 8'b11110000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle(5);

    // parity error: stop still strobed, no data_valid, IDLE one cycle after DONE
    send_frame(6'd32, 32, 8'b10110100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    check("perr_done_state", {busy, data_valid}, 32'd2);
    @(negedge clk);
    check("perr_idle_after", busy, 32'd0);
    idle(5);

    // stop error, P=8, no parity
    send_frame(6'd8, 8, 8'h5a, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    idle(5);

    // start glitch, P=8, then a genuine frame
    send_frame(6'd8, 8, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    check("glitch_idle", {busy, samp_en, edge_cnt, bit_cnt}, 32'd0);
    idle(5);
    send_frame(6'd8, 8, 8'hc3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle(5);

    // illegal prescale treated as 32; mid-frame config changes ignored
    send_frame(6'd10, 32, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle(5);

    // back-to-back: second start bit begins in the DONE cycle
    send_frame(6'd8, 8, 8'h3c, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    send_frame(6'd8, 8, 8'ha5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    send_frame(6'd16, 16, 8'h0f, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle(5);

    // reset asserted at t0+100, then recovery
    send_frame(6'd16, 16, 8'h99, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 100);
    idle(5);
    check("post_reset_idle", busy, 32'd0);
    send_frame(6'd16, 16, 8'h66, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle(5);

`ifdef UART_RX_GLITCH_FILTER_EN
    RX_IN = 1'b0;
    @(negedge clk);
    RX_IN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("filter_pulse_busy", busy, 32'd0);
    end
    send_frame(6'd32, 32, 8'b10110100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle(5);
`endif

    idle(10);
    check("pending_events", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
